match_controller: RTL
=====================

Name: match_controller

Overview:
Round/match sequencer that sits between the board inputs and the game core. It holds the core in reset between rounds and gates player inputs so the core only sees them during a fight. It runs the pre-fight countdown and the per-round timer, scores rounds from the core's finish flags or on timeout, and declares a best-of-N match winner to the VGA layer.

Parameters:
TICK_CYCLES, 100_000_000, clk cycles per 1 s game tick (benches use 10)
COUNTDOWN_SECS, 3, pre-fight countdown length in ticks (1..15)
ROUND_SECS, 99, round time limit in ticks (1..127)
BANNER_SECS, 2, round-end banner hold in ticks (>=1)
ROUNDS_TO_WIN, 2, round wins that end the match (1..3)
MAX_ROUNDS, 5, round count after which the match ends as a draw if nobody has ROUNDS_TO_WIN (1..7)
RST_PULSE_CYCLES, 16, cycles game_rst_n is held low per round (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low
start_btn  in  1  debounced start button, level
p1_inputs_in  in  7  raw P1 controls
p2_inputs_in  in  7  raw P2 controls
finish  in  2  core flags: 00 running, 01 P1 won, 11 P2 won
p1_health  in  4  core P1 health
p2_health  in  4  core P2 health
game_rst_n  out  1  active-low reset to game core
p1_inputs  out  7  gated P1 controls to core
p2_inputs  out  7  gated P2 controls to core
state  out  3  0 IDLE, 1 RESET_CORE, 2 COUNTDOWN, 3 FIGHT, 4 ROUND_END, 5 MATCH_END
countdown  out  4  remaining countdown ticks
round_timer  out  7  remaining round seconds
round_num  out  3  current round number, 1-based
p1_rounds  out  2  P1 round wins
p2_rounds  out  2  P2 round wins
round_result  out  2  last round: 00 none, 01 P1, 10 P2, 11 draw
match_winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset (reset==0 at a clk edge, in any state, mid-round included): next cycle state=IDLE, game_rst_n=0, inputs outputs=0, all counters, rounds, round_num and results=0, start edge register=0, tick counter=0.
- All outputs are registered.
- game_rst_n is 0 in IDLE and RESET_CORE and 1 in all other states.
- Start edge: start_btn high now and low in the previous cycle. It is acted on only in IDLE and MATCH_END and ignored elsewhere.
- Tick counter: counts 0..TICK_CYCLES-1 and raises tick for the one cycle where the count equals TICK_CYCLES-1, then wraps to 0. It is cleared on every state transition, so the first tick arrives TICK_CYCLES cycles after state entry.
- Input gating: p1_inputs/p2_inputs equal the *_in values registered one cycle earlier while state==FIGHT, and 0 in all other states, including the cycle FIGHT is left.
- IDLE:
  - On start edge, go to RESET_CORE.
  - Clear p1_rounds, p2_rounds, round_result and match_winner; set round_num=1.
- RESET_CORE: hold for exactly RST_PULSE_CYCLES cycles, then go to COUNTDOWN with countdown=COUNTDOWN_SECS.
- COUNTDOWN:
  - On each tick, countdown decrements.
  - On the tick where countdown==1, set countdown=0, round_timer=ROUND_SECS and go to FIGHT.
- FIGHT, checked in priority order:
  - (a) finish[0]==1: a round is scored. Winner is P2 if finish[1]==1, otherwise P1. Increment that player's round counter and set round_result to 01 or 10.
  - (b) Otherwise, on a tick with round_timer==1: round_timer=0 and the round is scored on health. Higher health wins and is incremented as in (a). Equal health sets round_result=11 and increments neither counter.
  - (c) Otherwise, a tick decrements round_timer.
  - After (a) or (b), go to ROUND_END.
  - finish and timeout in the same cycle: finish wins and the timer is left unchanged.
- ROUND_END: after BANNER_SECS ticks:
  - If p1_rounds==ROUNDS_TO_WIN, set match_winner=01 and go to MATCH_END.
  - Else if p2_rounds==ROUNDS_TO_WIN, set match_winner=10 and go to MATCH_END.
  - Else if round_num==MAX_ROUNDS, set match_winner=11 and go to MATCH_END.
  - Else increment round_num and go to RESET_CORE.
- MATCH_END: all outputs hold. On start edge, go to IDLE; match_winner stays until the IDLE start edge clears it.
- Counters never wrap. The round counters saturate structurally because the match ends on reaching ROUNDS_TO_WIN.
- finish and health are sampled only in FIGHT. Stale finish in other states is ignored.

Test Plan:
- Full P1 match: TICK_CYCLES=10, defaults. Start edge; 16 cycles later state=2; countdown 3,2,1; then FIGHT with round_timer=99. Drive finish=01 in round 1 and round 2. Expect p1_rounds=2, match_winner=01, state=5, and game_rst_n low for exactly 16 cycles before each round.
- Timeout on health: ROUND_SECS=3, health 9 vs 4. After 3 ticks in FIGHT, expect round_result=01 and p1_rounds=1. Repeat with 7 vs 7: expect round_result=11 and both counters unchanged.
- Draw cap: MAX_ROUNDS=3, three health-tie timeouts. Expect match_winner=11 after round 3 banner, with round_num=3.
- Simultaneous events: finish=11 asserted on the same cycle as the final tick with round_timer=1. Expect p2_rounds+1, round_result=10, round_timer=1.
- Gating and reset: p1_inputs_in=7'h7F. Outputs stay 0 in COUNTDOWN, equal 7F one cycle after FIGHT entry, and return to 0 in ROUND_END. Assert reset=0 mid-FIGHT: next cycle state=0, game_rst_n=0, all outputs 0.
- Start debounce: hold start_btn high through IDLE to MATCH_END with no new edge. Expect no transition out of MATCH_END until start_btn goes low then high.

Source files
------------

// File: rtl/match_controller.sv
// Round/match sequencer between board inputs and the game core: core reset pulses,
// input gating, countdown and round timers, round scoring and best-of-N match result.
module match_controller #(
  parameter int TICK_CYCLES      = 100_000_000,
  parameter int COUNTDOWN_SECS   = 3,
  parameter int ROUND_SECS       = 99,
  parameter int BANNER_SECS      = 2,
  parameter int ROUNDS_TO_WIN    = 2,
  parameter int MAX_ROUNDS       = 5,
  parameter int RST_PULSE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic [6:0] p1_inputs_in,
  input  logic [6:0] p2_inputs_in,
  input  logic [1:0] finish,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  output logic       game_rst_n,
  output logic [6:0] p1_inputs,
  output logic [6:0] p2_inputs,
  output logic [2:0] state,
  output logic [3:0] countdown,
  output logic [6:0] round_timer,
  output logic [2:0] round_num,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] round_result,
  output logic [1:0] match_winner
);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_RESET_CORE = 3'd1;
  localparam logic [2:0] S_COUNTDOWN  = 3'd2;
  localparam logic [2:0] S_FIGHT      = 3'd3;
  localparam logic [2:0] S_ROUND_END  = 3'd4;
  localparam logic [2:0] S_MATCH_END  = 3'd5;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RW = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int BW = (BANNER_SECS > 1) ? $clog2(BANNER_SECS) : 1;

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST    = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [BW-1:0] BANNER_LAST = BW'(BANNER_SECS - 1);
  localparam logic [3:0]    CD_INIT     = 4'(COUNTDOWN_SECS);
  localparam logic [6:0]    RT_INIT     = 7'(ROUND_SECS);
  localparam logic [1:0]    WIN_COUNT   = 2'(ROUNDS_TO_WIN);
  localparam logic [2:0]    LAST_ROUND  = 3'(MAX_ROUNDS);

  logic          start_prev;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] rst_cnt;
  logic [BW-1:0] banner_cnt;
  logic          start_edge;
  logic          tick;
  logic [2:0]    next_state;
  logic [1:0]    fight_result;
  logic [1:0]    end_winner;

  assign start_edge = start_btn && !start_prev;
  assign tick       = (tick_cnt == TICK_LAST);

  // Nonzero only on the cycle a round is decided; finish outranks a same-cycle timeout.
  always_comb begin
    fight_result = 2'b00;
    if (finish[0]) begin
      fight_result = finish[1] ? 2'b10 : 2'b01;
    end else if (tick && round_timer == 7'd1) begin
      if (p1_health > p2_health)      fight_result = 2'b01;
      else if (p2_health > p1_health) fight_result = 2'b10;
      else                            fight_result = 2'b11;
    end
  end

  always_comb begin
    end_winner = 2'b00;
    if (p1_rounds == WIN_COUNT)       end_winner = 2'b01;
    else if (p2_rounds == WIN_COUNT)  end_winner = 2'b10;
    else if (round_num == LAST_ROUND) end_winner = 2'b11;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (start_edge) next_state = S_RESET_CORE;
      S_RESET_CORE: if (rst_cnt == RST_LAST) next_state = S_COUNTDOWN;
      S_COUNTDOWN:  if (tick && countdown == 4'd1) next_state = S_FIGHT;
      S_FIGHT:      if (fight_result != 2'b00) next_state = S_ROUND_END;
      S_ROUND_END:
        if (tick && banner_cnt == BANNER_LAST)
          next_state = (end_winner != 2'b00) ? S_MATCH_END : S_RESET_CORE;
      S_MATCH_END:  if (start_edge) next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      game_rst_n   <= 1'b0;
      p1_inputs    <= '0;
      p2_inputs    <= '0;
      countdown    <= '0;
      round_timer  <= '0;
      round_num    <= '0;
      p1_rounds    <= '0;
      p2_rounds    <= '0;
      round_result <= '0;
      match_winner <= '0;
      start_prev   <= 1'b0;
      tick_cnt     <= '0;
      rst_cnt      <= '0;
      banner_cnt   <= '0;
    end else begin
      start_prev <= start_btn;
      state      <= next_state;
      // Outputs are derived from next_state so they line up with the registered state.
      game_rst_n <= (next_state != S_IDLE) && (next_state != S_RESET_CORE);
      p1_inputs  <= (next_state == S_FIGHT) ? p1_inputs_in : '0;
      p2_inputs  <= (next_state == S_FIGHT) ? p2_inputs_in : '0;

      if (next_state != state || tick) tick_cnt <= '0;
      else                             tick_cnt <= tick_cnt + TW'(1);

      if (state == S_RESET_CORE && next_state == S_RESET_CORE) rst_cnt <= rst_cnt + RW'(1);
      else                                                     rst_cnt <= '0;

      if (state != S_ROUND_END || next_state != S_ROUND_END) banner_cnt <= '0;
      else if (tick)                                         banner_cnt <= banner_cnt + BW'(1);

      case (state)
        S_IDLE: begin
          if (start_edge) begin
            p1_rounds    <= '0;
            p2_rounds    <= '0;
            round_result <= '0;
            match_winner <= '0;
            round_num    <= 3'd1;
          end
        end
        S_RESET_CORE: begin
          if (next_state == S_COUNTDOWN) countdown <= CD_INIT;
        end
        S_COUNTDOWN: begin
          if (tick) begin
            countdown <= countdown - 4'd1;
            if (countdown == 4'd1) round_timer <= RT_INIT;
          end
        end
        S_FIGHT: begin
          if (fight_result != 2'b00) begin
            round_result <= fight_result;
            if (fight_result == 2'b01) p1_rounds <= p1_rounds + 2'd1;
            if (fight_result == 2'b10) p2_rounds <= p2_rounds + 2'd1;
            if (!finish[0]) round_timer <= 7'd0;
          end else if (tick) begin
            round_timer <= round_timer - 7'd1;
          end
        end
        S_ROUND_END: begin
          if (tick && banner_cnt == BANNER_LAST) begin
            if (end_winner != 2'b00) match_winner <= end_winner;
            else                     round_num    <= round_num + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
